// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 triple decoder with sliding history; optional range check under ERR_CHECK_EN
module lz77_decoder #(
    parameter int              SEARCH_DEPTH = 9,
    parameter int              OFF_W        = 4,
    parameter int              LEN_W        = 3,
    parameter int              DW           = 8,
    parameter logic [DW-1:0]   END_CHAR     = 8'h24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OFF_W-1:0]   offset,
    input  logic [LEN_W-1:0]   match_len,
    input  logic [DW-1:0]      char_nxt,
    output logic [DW-1:0]      char_out,
    output logic               out_valid,
    output logic               finish,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // hist[0] is the most recently emitted character
    logic [DW-1:0]      hist [SEARCH_DEPTH];

    logic [OFF_W-1:0]   off_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [DW-1:0]      char_q;

    logic               take;
    logic               lit_end;
    logic               emit;
    logic [DW-1:0]      emit_char;
    logic [DW-1:0]      copy_char;

    // Entry addressed by the latched offset; indices past the array read as 0
    always_comb begin
        copy_char = '0;
        for (int i = 0; i < SEARCH_DEPTH; i++) begin
            if (off_q == OFF_W'(i)) begin
                copy_char = hist[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = (match_len != '0) ? COPY : LIT;
                end
            end
            COPY: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_nxt = LIT;
                end
            end
            LIT: begin
                if (lit_end) begin
                    state_nxt = DONE;
                end else if (take) begin
                    state_nxt = (match_len != '0) ? COPY : LIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and emit decode; a triple offered while the end marker is
    // being emitted is dropped because decoding stops there
    always_comb begin
        in_ready  = (state == IDLE) || (state == LIT);
        lit_end   = (state == LIT) && (char_q == END_CHAR);
        take      = in_valid && in_ready && !lit_end;
        emit      = (state == COPY) || (state == LIT);
        emit_char = (state == COPY) ? copy_char : char_q;
    end

    // Datapath: triple latch, run counter, history shift and registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                hist[i] <= '0;
            end
            off_q     <= '0;
            cnt_q     <= '0;
            char_q    <= '0;
            char_out  <= '0;
            out_valid <= 1'b0;
            finish    <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                char_out <= emit_char;
                hist[0]  <= emit_char;
                for (int i = 1; i < SEARCH_DEPTH; i++) begin
                    hist[i] <= hist[i-1];
                end
            end
            if (state == COPY) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
            if (take) begin
                off_q  <= offset;
                cnt_q  <= match_len;
                char_q <= char_nxt;
            end
            if (lit_end) begin
                finish <= 1'b1;
            end
        end
    end

`ifdef ERR_CHECK_EN
    localparam int FILL_W = $clog2(SEARCH_DEPTH + 1);

    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_eff;

    // Valid history depth at accept time, counting a literal leaving this edge
    always_comb begin
        fill_eff = fill;
        if ((state == LIT) && (fill != FILL_W'(SEARCH_DEPTH))) begin
            fill_eff = fill + FILL_W'(1);
        end
    end

    // Saturating count of emitted characters
    always_ff @(posedge clk) begin
        if (reset) begin
            fill <= '0;
        end else if (emit && (fill != FILL_W'(SEARCH_DEPTH))) begin
            fill <= fill + FILL_W'(1);
        end
    end

    // Sticky flag for a match that reaches past valid history
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (take && (match_len != '0) &&
                     ((int'(offset) >= int'(fill_eff)) || (int'(offset) >= SEARCH_DEPTH))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// tb/tb_lz77_decoder.sv - directed and randomized checks of lz77_decoder against a history-queue model
`timescale 1ns/1ps
module tb_lz77_decoder;

    localparam int          DEPTH = 9;
    localparam logic [7:0]  ENDC  = 8'h24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] offset = '0;
    logic [2:0] match_len = '0;
    logic [7:0] char_nxt = '0;
    logic       in_ready;
    logic [7:0] char_out;
    logic       out_valid;
    logic       finish;
    logic       err;

    lz77_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .offset    (offset),
        .match_len (match_len),
        .char_nxt  (char_nxt),
        .char_out  (char_out),
        .out_valid (out_valid),
        .finish    (finish),
        .err       (err)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;

    byte unsigned m_hist[$];
    byte unsigned exp_q[$];
    int           m_fill;
    bit           m_done;
    bit           exp_err;

    byte unsigned got[$];
    int           got_cyc[$];
    int           cyc = 0;
    bit           exp_fin = 1'b0;
    byte unsigned last_char = 8'h00;
    bit           rst_s;
    byte unsigned e;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < DEPTH; i++) m_hist.push_back(8'h00);
        exp_q.delete();
        m_fill  = 0;
        m_done  = 1'b0;
        exp_err = 1'b0;
    endfunction

    function automatic void model_emit(byte unsigned c);
        exp_q.push_back(c);
        m_hist.push_front(c);
        void'(m_hist.pop_back());
        if (m_fill < DEPTH) m_fill++;
    endfunction

    function automatic void model_push(int o, int l, byte unsigned c);
        byte unsigned v;
        if (m_done) return;
`ifdef ERR_CHECK_EN
        if (l != 0 && (o >= m_fill || o >= DEPTH)) exp_err = 1'b1;
`endif
        for (int k = 0; k < l; k++) begin
            v = (o < DEPTH) ? m_hist[o] : 8'h00;
            model_emit(v);
        end
        model_emit(c);
        if (c == ENDC) m_done = 1'b1;
    endfunction

    // Every posedge: sample #1 later and compare against the model queue
    always @(posedge clk) begin
        cyc++;
        rst_s = reset;
        #1;
        if (rst_s) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_char_out", char_out, 0);
            chk("rst_finish", finish, 0);
            chk("rst_err", err, 0);
            chk("rst_in_ready", in_ready, 1);
            last_char = 8'h00;
            exp_fin   = 1'b0;
        end else begin
            if (out_valid) begin
                got.push_back(char_out);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got char 0x%0h, required no output", char_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e == ENDC) exp_fin = 1'b1;
                    chk("char_out", char_out, e);
                end
                last_char = char_out;
            end else begin
                chk("hold_char_out", char_out, last_char);
            end
            chk("finish", finish, exp_fin);
            chk("err", err, exp_err);
        end
    end

    task automatic send(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c, input int gap);
        int n = 0;
        in_valid  = 1'b1;
        offset    = o;
        match_len = l;
        char_nxt  = c;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 64 cycles");
            in_valid = 1'b0;
            return;
        end
        model_push(int'(o), int'(l), c);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_seq(string name, int base, string s);
        string act = "";
        for (int i = base; i < got.size(); i++) act = $sformatf("%s%c", act, got[i]);
        checks++;
        if (act != s) begin
            failures++;
            $display("FAIL %s: got \"%s\", required \"%s\"", name, act, s);
        end
    endtask

    initial begin
        int base;
        int acc;
        int len;
        int off;
        int gap;
        logic [7:0] c;

        model_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // back-to-back literals then a copy
        base = got.size();
        acc  = cyc + 1;
        send(4'd0, 3'd0, "a", 0);
        send(4'd0, 3'd0, "b", 0);
        send(4'd1, 3'd3, "c", 0);
        drain();
        check_seq("seq_ababac", base, "ababac");
        chk("first_latency", got_cyc[base], acc + 1);
        chk("gap_free_span", got_cyc[base+5] - got_cyc[base], 5);

        // self-overlapping run
        base = got.size();
        send(4'd0, 3'd0, "x", 0);
        send(4'd0, 3'd4, "y", 0);
        for (int i = 0; i < 4; i++) begin
            chk("copy_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("lit_in_ready", in_ready, 1);
        drain();
        check_seq("seq_xxxxxy", base, "xxxxxy");

        // end marker
        base = got.size();
        send(4'd0, 3'd0, "h", 0);
        send(4'd0, 3'd0, "$", 0);
        in_valid  = 1'b1;
        offset    = 4'd0;
        match_len = 3'd2;
        char_nxt  = "w";
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("done_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check_seq("seq_end", base, "h$");
        chk("finish_sticky", finish, 1);
        do_reset();

        // input gap while idle
        base = got.size();
        send(4'd0, 3'd0, "q", 3);
        send(4'd0, 3'd2, "z", 0);
        drain();
        repeat (3) @(negedge clk);
        check_seq("seq_qqqz", base, "qqqz");
        chk("idle_out_valid", out_valid, 0);
        chk("idle_char_hold", char_out, 8'h7a);

        // reset in the second copy cycle
        send(4'd0, 3'd5, "k", 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("post_rst_in_ready", in_ready, 1);
        base = got.size();
        send(4'd0, 3'd0, "m", 0);
        send(4'd0, 3'd1, "n", 0);
        drain();
        check_seq("seq_restart", base, "mmn");

        // match reaching past valid history
        do_reset();
        base = got.size();
        send(4'd2, 3'd1, "a", 0);
        drain();
        chk("oob_first", got[base], 8'h00);
        chk("oob_second", got[base+1], 8'h61);
        chk("oob_err", err, exp_err);

        // randomized legal stream
        do_reset();
        for (int t = 0; t < 300; t++) begin
            len = (m_fill == 0) ? 0 : int'($urandom_range(0, 7));
            off = (m_fill == 0) ? 0 : int'($urandom_range(0, m_fill - 1));
            c   = 8'($urandom_range(65, 90));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send(off[3:0], len[2:0], c, gap);
        end
        send(4'd0, 3'd0, "$", 0);
        drain();
        chk("rand_finish", finish, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
